// File: rtl/transform_pkg.sv
// transform_pkg: shared state encoding, fixed-point constants and coordinate type
// for the vertex transform path.
package transform_pkg;
    localparam int COORD_W_DEF = 10;
    localparam int TRIG_W      = 21;
    localparam int FX_SCALE    = 1000;
    typedef logic signed [COORD_W_DEF-1:0] coord_t;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_XFORM, S_EMIT, S_DONE
    } state_t;
endpackage

// File: rtl/xform_wait_counter.sv
// xform_wait_counter: loadable down-counter with zero flag, used to time
// multicycle datapath settling.
module xform_wait_counter
    import transform_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign zero = cnt_q == '0;
endmodule

// File: rtl/transform_sequencer.sv
// transform_sequencer: walks a vertex ROM through the shared combinational
// transform datapath one vertex at a time and emits results over valid/ready.
module transform_sequencer
    import transform_pkg::*;
#(
    parameter int NUM_VERTS = 8,
    parameter int ADDR_W    = 3,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int XFORM_LAT = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               param_latch,
    output logic               vert_rd,
    output logic [ADDR_W-1:0]  vert_addr,
    input  logic [COORD_W-1:0] vert_x,
    input  logic [COORD_W-1:0] vert_y,
    input  logic [COORD_W-1:0] vert_z,
    output logic [COORD_W-1:0] xf_x,
    output logic [COORD_W-1:0] xf_y,
    output logic [COORD_W-1:0] xf_z,
    input  logic [COORD_W-1:0] res_x,
    input  logic [COORD_W-1:0] res_y,
    input  logic [COORD_W-1:0] res_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COORD_W-1:0] out_z,
    output logic [ADDR_W-1:0]  out_idx
);
    localparam int CNT_W = $clog2(XFORM_LAT) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_VERTS - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic [3*COORD_W-1:0]   xf_q, out_q;
    logic [ADDR_W-1:0]      out_idx_q;
    logic                   cnt_zero;
    logic                   capture;

    xform_wait_counter #(.W(CNT_W)) u_wait (
        .clock    (clock),
        .resetn   (resetn),
        .load     (state_q == S_LOAD),
        .dec      (state_q == S_XFORM),
        .load_val (CNT_W'(XFORM_LAT - 1)),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_XFORM;
            S_XFORM: state_d = cnt_zero ? S_EMIT : S_XFORM;
            S_EMIT:  if (out_ready) begin
                state_d = (idx_q == LAST) ? S_DONE : S_FETCH;
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins over every transition, including start in IDLE
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end

    assign capture = state_q == S_XFORM && cnt_zero && !abort;

    // xf_q holds from LOAD through EMIT, making res_* a multicycle path
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            xf_q      <= '0;
            out_q     <= '0;
            out_idx_q <= '0;
        end else begin
            if (state_q == S_LOAD) xf_q <= {vert_x, vert_y, vert_z};
            if (capture) begin
                out_q     <= {res_x, res_y, res_z};
                out_idx_q <= idx_q;
            end
        end

    assign busy        = state_q != S_IDLE;
    assign done        = state_q == S_DONE;
    assign vert_rd     = state_q == S_FETCH;
    assign param_latch = state_q == S_FETCH && idx_q == '0;
    assign out_valid   = state_q == S_EMIT;
    assign vert_addr   = idx_q;
    assign out_idx     = out_idx_q;
    assign {xf_x, xf_y, xf_z}    = xf_q;
    assign {out_x, out_y, out_z} = out_q;
endmodule

// File: tb/tb_transform_sequencer.sv
// tb_transform_sequencer: directed scenarios with a queue-based scoreboard on
// the output handshake, plus a single-vertex instance for the short-latency case.
module tb_transform_sequencer;
    localparam int CW = 10;
    localparam int AW = 3;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int pl_cnt = 0;

    logic start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic busy, done, param_latch, vert_rd, out_valid;
    logic [AW-1:0] vert_addr, out_idx;
    logic [CW-1:0] vert_x = '0, vert_y = '0, vert_z = '0;
    logic [CW-1:0] xf_x, xf_y, xf_z, res_x, res_y, res_z, out_x, out_y, out_z;

    transform_sequencer #(.NUM_VERTS(8), .ADDR_W(AW), .COORD_W(CW), .XFORM_LAT(2)) dut (
        .clock(clock), .resetn(resetn), .start(start), .abort(abort),
        .busy(busy), .done(done), .param_latch(param_latch), .vert_rd(vert_rd),
        .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y), .vert_z(vert_z),
        .xf_x(xf_x), .xf_y(xf_y), .xf_z(xf_z), .res_x(res_x), .res_y(res_y), .res_z(res_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_idx(out_idx)
    );

    always @(posedge clock)
        if (vert_rd) begin
            vert_x <= CW'(int'(vert_addr));
            vert_y <= CW'(-int'(vert_addr));
            vert_z <= CW'(2 * int'(vert_addr));
        end
    assign res_x = xf_x + CW'(1);
    assign res_y = xf_y + CW'(1);
    assign res_z = xf_z + CW'(1);

    logic b_start = 1'b0, b_abort = 1'b0, b_out_ready = 1'b1;
    logic b_busy, b_done, b_param_latch, b_vert_rd, b_out_valid;
    logic [0:0] b_vert_addr, b_out_idx;
    logic [CW-1:0] b_vert_x = '0, b_vert_y = '0, b_vert_z = '0;
    logic [CW-1:0] b_xf_x, b_xf_y, b_xf_z, b_res_x, b_res_y, b_res_z, b_out_x, b_out_y, b_out_z;

    transform_sequencer #(.NUM_VERTS(1), .ADDR_W(1), .COORD_W(CW), .XFORM_LAT(1)) dut_b (
        .clock(clock), .resetn(resetn), .start(b_start), .abort(b_abort),
        .busy(b_busy), .done(b_done), .param_latch(b_param_latch), .vert_rd(b_vert_rd),
        .vert_addr(b_vert_addr), .vert_x(b_vert_x), .vert_y(b_vert_y), .vert_z(b_vert_z),
        .xf_x(b_xf_x), .xf_y(b_xf_y), .xf_z(b_xf_z), .res_x(b_res_x), .res_y(b_res_y), .res_z(b_res_z),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_x(b_out_x), .out_y(b_out_y), .out_z(b_out_z), .out_idx(b_out_idx)
    );

    always @(posedge clock)
        if (b_vert_rd) begin
            b_vert_x <= CW'(int'(b_vert_addr));
            b_vert_y <= CW'(-int'(b_vert_addr));
            b_vert_z <= CW'(2 * int'(b_vert_addr));
        end
    assign b_res_x = b_xf_x + CW'(1);
    assign b_res_y = b_xf_y + CW'(1);
    assign b_res_z = b_xf_z + CW'(1);

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } vtx_t;
    vtx_t exp_q[$];

    task automatic push_verts(input int count);
        vtx_t v;
        for (int i = 0; i < count; i++) begin
            v.idx = AW'(i);
            v.x   = CW'(i + 1);
            v.y   = CW'(1 - i);
            v.z   = CW'(2 * i + 1);
            exp_q.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (param_latch) pl_cnt++;
        if (resetn && out_valid && out_ready) begin
            vtx_t a, e;
            a.idx = out_idx;
            a.x = out_x;
            a.y = out_y;
            a.z = out_z;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got idx=%0d xyz=%0h/%0h/%0h with no expected vertex", a.idx, a.x, a.y, a.z);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL sb_vertex: got idx=%0d xyz=%0h/%0h/%0h expected idx=%0d xyz=%0h/%0h/%0h",
                             a.idx, a.x, a.y, a.z, e.idx, e.x, e.y, e.z);
                end
            end
        end
    end

    // Runs one pass from start; returns the cycle (k+n) at which done was seen, -1 on timeout.
    task automatic run_pass(input int bp_vert, input bit poke_start, output int n_done);
        int n;
        bit held;
        logic [AW+3*CW-1:0] hold;
        held = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check("first_fetch", {busy, param_latch, vert_rd, vert_addr}, {1'b1, 1'b1, 1'b1, 3'd0});
        while (n < 300 && !done) begin
            if (bp_vert >= 0 && !held && out_valid && out_idx == AW'(bp_vert)) begin
                held = 1'b1;
                out_ready = 1'b0;
                hold = {out_idx, out_x, out_y, out_z};
                for (int j = 0; j < 10; j++) begin
                    tick();
                    n++;
                    check("bp_hold", {out_valid, vert_rd, out_idx, out_x, out_y, out_z}, {1'b1, 1'b0, hold});
                end
                out_ready = 1'b1;
            end
            start = poke_start && n == 12;
            tick();
            n++;
        end
        start = 1'b0;
        n_done = done ? n : -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, pl0, n;
        bit bad;
        repeat (3) @(negedge clock);
        check("reset_ctrl", {busy, done, param_latch, vert_rd, vert_addr, out_valid, out_idx}, 0);
        check("reset_data", {xf_x, xf_y, xf_z, out_x, out_y, out_z}, 0);
        resetn = 1'b1;
        tick();
        tick();
        check("idle_no_start", {busy, vert_rd}, 0);

        push_verts(8);
        pl0 = pl_cnt;
        run_pass(-1, 1'b1, nd);
        check("pass_done_cycle", nd, 41);
        check("param_latch_once", pl_cnt - pl0, 1);
        tick();
        check("done_one_cycle_idle", {busy, done}, 0);
        check("sb_empty_pass1", exp_q.size(), 0);

        push_verts(8);
        run_pass(3, 1'b0, nd);
        check("bp_done_cycle", nd, 51);
        tick();
        check("sb_empty_bp", exp_q.size(), 0);

        push_verts(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 300 && !(vert_rd && vert_addr == 3'd5)) begin
            tick();
            n++;
        end
        check("reach_vertex5", n < 300, 1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {busy, out_valid, done, vert_rd, vert_addr}, 0);
        bad = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            bad |= busy | done | out_valid;
        end
        check("abort_stays_idle", bad, 0);
        check("sb_empty_abort", exp_q.size(), 0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", {busy, vert_rd, vert_addr}, 0);
        tick();
        check("start_abort_still_idle", busy, 0);

        push_verts(8);
        run_pass(-1, 1'b0, nd);
        check("restart_done_cycle", nd, 41);
        tick();

        push_verts(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 300 && !(out_valid && out_idx == 3'd1)) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("reach_emit1", {n < 300, out_x}, {1'b1, CW'(2)});
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_ctrl", {busy, done, param_latch, vert_rd, vert_addr, out_valid, out_idx}, 0);
        check("async_reset_data", {xf_x, xf_y, xf_z, out_x, out_y, out_z}, 0);
        @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        bad = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            bad |= busy | vert_rd | out_valid;
        end
        check("post_reset_idle", bad, 0);
        check("sb_empty_reset", exp_q.size(), 0);

        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 1;
        while (n < 50 && !b_out_valid) begin
            tick();
            n++;
        end
        check("b_first_valid_cycle", n, 4);
        check("b_out", {b_out_idx, b_out_x, b_out_y, b_out_z}, {1'b0, CW'(1), CW'(1), CW'(1)});
        tick();
        check("b_done", {b_done, b_out_valid}, {1'b1, 1'b0});
        tick();
        check("b_idle", {b_done, b_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
